// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: widths, opcodes, instruction
// field positions and the fetch queue entry layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    // Sequential word address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; the head is read
// straight from storage so a pushed entry is visible the cycle after the push.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_push_data,
    input  logic          i_pop,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, credit-limited in-order requests to instruction memory,
// response queue towards decode, and redirect flush with late-response drop.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [CW:0]     w_inflight;
    logic [XLEN-1:0] w_target;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_dec_valid;
    logic [CW-1:0]   w_q_count;
    logic            w_q_empty;
    logic            w_q_full;
    fetch_entry_t    w_q_head;
    fetch_entry_t    w_push_entry;
    logic [31:0]     w_instr;

    // Requests in flight plus queued entries never exceed the queue depth.
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_q_count};
    assign w_req_valid = !rst && !redirect_valid && !w_q_full
                         && (w_inflight < (CW + 1)'(QDEPTH));
    assign w_accept    = w_req_valid && imem_req_ready;
    assign w_rsp_drop  = imem_rsp_valid && (r_drop != '0);
    assign w_push      = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_dec_valid = !rst && !w_q_empty;
    assign w_pop       = w_dec_valid && dec_ready && !redirect_valid;
    assign w_target    = redirect_pc & {{(XLEN - 2){1'b1}}, 2'b00};

    assign w_push_entry.pc    = r_rsp_pc;
    assign w_push_entry.instr = imem_rsp_data;

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_q_head),
        .o_count     (w_q_count),
        .o_empty     (w_q_empty),
        .o_full      (w_q_full)
    );

    always_comb begin
        w_out_nxt = r_outstanding;
        case ({w_accept, imem_rsp_valid})
            2'b10:   w_out_nxt = r_outstanding + CW'(1);
            2'b01:   w_out_nxt = r_outstanding - CW'(1);
            default: w_out_nxt = r_outstanding;
        endcase
    end

    // On redirect every response still owed after this cycle is stale.
    always_comb begin
        w_drop_nxt = r_drop;
        if (redirect_valid) begin
            w_drop_nxt = w_out_nxt;
        end else if (w_rsp_drop) begin
            w_drop_nxt = r_drop - CW'(1);
        end else begin
            w_drop_nxt = r_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_drop        <= w_drop_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= pc_plus4(r_fetch_pc);
                end
                if (w_push) begin
                    r_rsp_pc <= pc_plus4(r_rsp_pc);
                end
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;

    // Decode sees an all-zero instruction (opcode 0, no writes) when idle.
    assign dec_valid = w_dec_valid;
    assign w_instr   = w_dec_valid ? w_q_head.instr : 32'h0000_0000;
    assign dec_instr = w_instr;
    assign dec_pc    = w_dec_valid ? w_q_head.pc : '0;
    assign opcode    = w_instr[OPCODE_MSB:OPCODE_LSB];
    assign funct3    = w_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7    = w_instr[FUNCT7_MSB:FUNCT7_LSB];
    assign rd        = w_instr[RD_MSB:RD_LSB];
    assign rs1       = w_instr[RS1_MSB:RS1_LSB];
    assign rs2       = w_instr[RS2_MSB:RS2_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency in-order memory model.
module tb_instr_fetch;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    int n_vec = 0;
    int n_bad = 0;
    int mem_lat = 1;
    int e_cnt = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pq[$];

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h00A0_0093;
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory: a request accepted at edge e responds during the cycle after edge e+lat-1.
    always @(posedge clk) begin
        if (rst) begin
            pq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            acc_cnt        <= 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pq.push_back('{imem_req_addr, e_cnt + mem_lat - 1});
                acc_cnt <= acc_cnt + 1;
            end
            if (pq.size() > 0 && pq[0].due <= e_cnt) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= memword(pq[0].addr);
                void'(pq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
        e_cnt <= e_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_req_ready = 1'b1;
        mem_lat = lat;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        dec_ready = 1'b1;

        // Streaming at latency 1 with decode always ready.
        do_reset(1);
        dec_ready = 1'b1;
        @(negedge clk);
        chk("t1_req_valid_b", 32'(imem_req_valid), 32'd1);
        chk("t1_addr_b", imem_req_addr, 32'h4);
        chk("t1_dec_valid_b", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t1_dec_valid_c", 32'(dec_valid), 32'd1);
        chk("t1_dec_pc_c", dec_pc, 32'h0);
        chk("t1_instr_c", dec_instr, 32'h00A0_0093);
        chk("t1_opcode", 32'(opcode), 32'(OP_I));
        chk("t1_funct3", 32'(funct3), 32'd0);
        chk("t1_funct7", 32'(funct7), 32'd0);
        chk("t1_rd", 32'(rd), 32'd1);
        chk("t1_rs1", 32'(rs1), 32'd0);
        chk("t1_rs2", 32'(rs2), 32'd10);
        chk("t1_req_valid_c", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        chk("t1_dec_pc_d", dec_pc, 32'h4);
        chk("t1_addr_d", imem_req_addr, 32'h8);
        @(negedge clk);
        chk("t1_dec_valid_e", 32'(dec_valid), 32'd0);
        chk("t1_idle_opcode", 32'(opcode), 32'd0);
        chk("t1_idle_rd", 32'(rd), 32'd0);
        chk("t1_idle_instr", dec_instr, 32'd0);
        chk("t1_addr_e", imem_req_addr, 32'hC);
        @(negedge clk);
        chk("t1_dec_pc_f", dec_pc, 32'h8);
        chk("t1_instr_f", dec_instr, memword(32'h8));

        // Decode stalled: exactly QDEPTH requests, then drain in order.
        do_reset(1);
        dec_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_acc_cnt", 32'(acc_cnt), 32'd2);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_dec_pc0", dec_pc, 32'h0);
        dec_ready = 1'b1;
        @(negedge clk);
        chk("t2_dec_pc1", dec_pc, 32'h4);
        chk("t2_addr", imem_req_addr, 32'h8);
        @(negedge clk);
        chk("t2_dec_valid_gap", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t2_dec_pc2", dec_pc, 32'h8);
        rst = 1'b1;
        #1;
        chk("t2_rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("t2_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_rst_opcode", 32'(opcode), 32'd0);

        // Redirect with two requests outstanding at latency 3.
        do_reset(3);
        dec_ready = 1'b1;
        @(negedge clk);
        chk("t3_addr_b", imem_req_addr, 32'h4);
        @(negedge clk);
        chk("t3_credit_stall", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("t3_target_addr", imem_req_addr, 32'h100);
        chk("t3_req_during_redir", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_req_valid_e", 32'(imem_req_valid), 32'd1);
        chk("t3_addr_e", imem_req_addr, 32'h100);
        chk("t3_dec_valid_e", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t3_addr_f", imem_req_addr, 32'h104);
        chk("t3_dec_valid_f", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t3_dec_valid_g", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t3_dec_valid_h", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t3_dec_valid_i", 32'(dec_valid), 32'd1);
        chk("t3_dec_pc_i", dec_pc, 32'h100);
        chk("t3_instr_i", dec_instr, memword(32'h100));
        @(negedge clk);
        chk("t3_dec_pc_j", dec_pc, 32'h104);

        // Memory not ready: address held, fetch resumes at the same PC.
        do_reset(1);
        dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_addr_d", imem_req_addr, 32'h8);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_addr_hold", imem_req_addr, 32'h8);
            chk("t4_req_valid_hold", 32'(imem_req_valid), 32'd1);
        end
        chk("t4_acc_cnt", 32'(acc_cnt), 32'd2);
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("t4_addr_resume", imem_req_addr, 32'hC);
        @(negedge clk);
        chk("t4_dec_pc", dec_pc, 32'h8);

        // Address wrap from the top word, redirect target alignment.
        do_reset(1);
        dec_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        chk("t5_req_redir", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_addr_wrap", imem_req_addr, 32'h0);
        chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        chk("t5_dec_pc", dec_pc, 32'hFFFF_FFFC);
        chk("t5_instr", dec_instr, memword(32'hFFFF_FFFC));

        // Reset while two stale responses are pending drop.
        do_reset(3);
        dec_ready = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("t6_dec_valid_d", 32'(dec_valid), 32'd0);
        redirect_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_dec", 32'(dec_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_restart_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("t6_addr_g", imem_req_addr, 32'h4);
        chk("t6_dec_valid_g", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t6_dec_valid_h", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t6_dec_valid_i", 32'(dec_valid), 32'd0);
        @(negedge clk);
        chk("t6_dec_valid_j", 32'(dec_valid), 32'd1);
        chk("t6_dec_pc_j", dec_pc, 32'h0);
        chk("t6_instr_j", dec_instr, 32'h00A0_0093);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
